// File: rtl/axi4_arb_pkg.sv
// Shared types and constants for the AXI4 read-channel arbiter.
// Optional feature macro: AXI4_ARB_STATS_EN (per-master grant counters).
package axi4_arb_pkg;

   localparam int unsigned NUM_MASTERS = 2;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   localparam int unsigned CNT_WIDTH = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2
   } arb_state_e;

   // Saturating increment: holds at all-ones instead of wrapping.
   function automatic logic [CNT_WIDTH-1:0] sat_inc16(input logic [CNT_WIDTH-1:0] val);
      logic [CNT_WIDTH-1:0] res;
      if (val == {CNT_WIDTH{1'b1}}) begin
         res = val;
      end else begin
         res = val + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end
      return res;
   endfunction

endpackage

// File: rtl/axi4_rr_arbiter.sv
// Two-requester round-robin pick. Purely combinational; the caller owns
// the last_grant history so the same pick can serve read and write arbiters.
module axi4_rr_arbiter
   import axi4_arb_pkg::*;
(
   input  logic [1:0] req_i,
   input  logic       last_grant_i,
   output logic       grant_o,
   output logic       valid_o
);

   // Lone requester wins; on a tie the master that was not served last wins.
   always_comb begin
      valid_o = |req_i;
      grant_o = 1'b0;
      case (req_i)
         2'b01:   grant_o = 1'b0;
         2'b10:   grant_o = 1'b1;
         2'b11:   grant_o = ~last_grant_i;
         default: grant_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/axi4_read_arbiter.sv
// Two-master, one-slave AXI4 read-channel arbiter. One burst in flight at a
// time; AR is forwarded in ADDR, R beats are routed to the granted master in
// DATA until the RLAST handshake. All outputs are muxes of registered state
// and pass-through inputs, so the R path has zero latency.
// Optional feature macro: AXI4_ARB_STATS_EN adds saturating per-master
// AR-handshake counters on output grant_cnt.
module axi4_read_arbiter
   import axi4_arb_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 16
) (
   input  logic                    ACLK,
   input  logic                    ARESET,
   input  logic [2*ADDR_WIDTH-1:0] m_araddr,
   input  logic [15:0]             m_arlen,
   input  logic [5:0]              m_arsize,
   input  logic [1:0]              m_arvalid,
   output logic [1:0]              m_arready,
   output logic [2*DATA_WIDTH-1:0] m_rdata,
   output logic [3:0]              m_rresp,
   output logic [1:0]              m_rvalid,
   output logic [1:0]              m_rlast,
   input  logic [1:0]              m_rready,
   output logic [ADDR_WIDTH-1:0]   s_araddr,
   output logic [7:0]              s_arlen,
   output logic [2:0]              s_arsize,
   output logic                    s_arvalid,
   input  logic                    s_arready,
   input  logic [DATA_WIDTH-1:0]   s_rdata,
   input  logic [1:0]              s_rresp,
   input  logic                    s_rvalid,
   input  logic                    s_rlast,
   output logic                    s_rready
`ifdef AXI4_ARB_STATS_EN
   ,
   output logic [2*CNT_WIDTH-1:0]  grant_cnt
`endif
);

   arb_state_e state_q, state_d;
   logic       grant_q, grant_d;
   logic       last_grant_q, last_grant_d;
   logic       arb_grant_s;
   logic       arb_valid_s;
   logic       ar_hs_s;
   logic       r_last_hs_s;

   axi4_rr_arbiter u_rr (
      .req_i        (m_arvalid),
      .last_grant_i (last_grant_q),
      .grant_o      (arb_grant_s),
      .valid_o      (arb_valid_s)
   );

   // Handshake qualifiers used by both the FSM and the optional counters.
   assign ar_hs_s     = (state_q == ADDR) && m_arvalid[grant_q] && s_arready;
   assign r_last_hs_s = (state_q == DATA) && s_rvalid && m_rready[grant_q] && s_rlast;

   // State, grant and fairness history registers; last_grant resets to 1 so master 0 wins the first tie.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         state_q      <= IDLE;
         grant_q      <= 1'b0;
         last_grant_q <= 1'b1;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
      end
   end

   // Next-state logic: arbitrate in IDLE, wait for AR handshake in ADDR, wait for RLAST in DATA.
   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      case (state_q)
         IDLE: begin
            if (arb_valid_s) begin
               grant_d = arb_grant_s;
               state_d = ADDR;
            end else begin
               state_d = IDLE;
            end
         end
         ADDR: begin
            // A master withdrawing arvalid is a protocol violation; drop the grant without
            // touching last_grant so fairness history is not disturbed.
            if (!m_arvalid[grant_q]) begin
               state_d = IDLE;
            end else if (s_arready) begin
               state_d = DATA;
            end else begin
               state_d = ADDR;
            end
         end
         DATA: begin
            if (r_last_hs_s) begin
               last_grant_d = grant_q;
               state_d      = IDLE;
            end else begin
               state_d = DATA;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Output muxes: everything idles at zero, ADDR exposes the granted AR, DATA routes R to the granted master.
   always_comb begin
      s_araddr  = {ADDR_WIDTH{1'b0}};
      s_arlen   = 8'd0;
      s_arsize  = 3'd0;
      s_arvalid = 1'b0;
      m_arready = 2'b00;
      m_rdata   = {(2*DATA_WIDTH){1'b0}};
      m_rresp   = 4'd0;
      m_rvalid  = 2'b00;
      m_rlast   = 2'b00;
      s_rready  = 1'b0;
      case (state_q)
         IDLE: begin
            s_arvalid = 1'b0;
         end
         ADDR: begin
            s_araddr           = grant_q ? m_araddr[2*ADDR_WIDTH-1:ADDR_WIDTH] : m_araddr[ADDR_WIDTH-1:0];
            s_arlen            = grant_q ? m_arlen[15:8] : m_arlen[7:0];
            s_arsize           = grant_q ? m_arsize[5:3] : m_arsize[2:0];
            s_arvalid          = m_arvalid[grant_q];
            m_arready[grant_q] = s_arready;
         end
         DATA: begin
            s_rready          = m_rready[grant_q];
            m_rvalid[grant_q] = s_rvalid;
            m_rlast[grant_q]  = s_rlast;
            m_rdata           = grant_q ? {s_rdata, {DATA_WIDTH{1'b0}}} : {{DATA_WIDTH{1'b0}}, s_rdata};
            m_rresp           = grant_q ? {s_rresp, 2'b00} : {2'b00, s_rresp};
         end
         default: begin
            s_arvalid = 1'b0;
         end
      endcase
   end

`ifdef AXI4_ARB_STATS_EN
   logic [1:0][CNT_WIDTH-1:0] cnt_q, cnt_d;

   // Count completed AR handshakes per master, saturating at all-ones.
   always_comb begin
      cnt_d = cnt_q;
      if (ar_hs_s) begin
         cnt_d[grant_q] = sat_inc16(cnt_q[grant_q]);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Counter registers, cleared with the rest of the block.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         cnt_q <= {(2*CNT_WIDTH){1'b0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign grant_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_axi4_read_arbiter.sv
// Directed table-driven bench for axi4_read_arbiter: one vector per clock,
// expected outputs hand-computed, plus a reset-mid-burst sequence.
module tb_axi4_read_arbiter;
   import axi4_arb_pkg::*;

   localparam int unsigned DW = 32;
   localparam int unsigned AW = 16;
   localparam int unsigned OW = 103;

   localparam logic [15:0] A0 = 16'h0010;
   localparam logic [15:0] A1 = 16'h2000;
   localparam logic [7:0]  L0 = 8'd0;
   localparam logic [7:0]  L1 = 8'd3;
   localparam logic [2:0]  S0 = 3'd2;
   localparam logic [2:0]  S1 = 3'd1;
   localparam logic [31:0] Z  = 32'h0000_0000;
   localparam logic [1:0]  OK = RESP_OKAY;
   localparam logic [1:0]  SE = RESP_SLVERR;

   logic            ACLK;
   logic            ARESET;
   logic [2*AW-1:0] m_araddr;
   logic [15:0]     m_arlen;
   logic [5:0]      m_arsize;
   logic [1:0]      m_arvalid;
   logic [1:0]      m_arready;
   logic [2*DW-1:0] m_rdata;
   logic [3:0]      m_rresp;
   logic [1:0]      m_rvalid;
   logic [1:0]      m_rlast;
   logic [1:0]      m_rready;
   logic [AW-1:0]   s_araddr;
   logic [7:0]      s_arlen;
   logic [2:0]      s_arsize;
   logic            s_arvalid;
   logic            s_arready;
   logic [DW-1:0]   s_rdata;
   logic [1:0]      s_rresp;
   logic            s_rvalid;
   logic            s_rlast;
   logic            s_rready;
`ifdef AXI4_ARB_STATS_EN
   logic [31:0]     grant_cnt;
`endif

   axi4_read_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .ACLK      (ACLK),
      .ARESET    (ARESET),
      .m_araddr  (m_araddr),
      .m_arlen   (m_arlen),
      .m_arsize  (m_arsize),
      .m_arvalid (m_arvalid),
      .m_arready (m_arready),
      .m_rdata   (m_rdata),
      .m_rresp   (m_rresp),
      .m_rvalid  (m_rvalid),
      .m_rlast   (m_rlast),
      .m_rready  (m_rready),
      .s_araddr  (s_araddr),
      .s_arlen   (s_arlen),
      .s_arsize  (s_arsize),
      .s_arvalid (s_arvalid),
      .s_arready (s_arready),
      .s_rdata   (s_rdata),
      .s_rresp   (s_rresp),
      .s_rvalid  (s_rvalid),
      .s_rlast   (s_rlast),
      .s_rready  (s_rready)
`ifdef AXI4_ARB_STATS_EN
      ,
      .grant_cnt (grant_cnt)
`endif
   );

   // Free-running clock, 10 time-unit period.
   initial ACLK = 1'b0;
   always #5 ACLK = ~ACLK;

   logic [OW-1:0] obs;
   assign obs = {s_arvalid, s_araddr, s_arlen, s_arsize, m_arready, m_rvalid, m_rlast,
                 m_rdata, m_rresp, s_rready};

   typedef struct {
      logic [1:0]    arv;
      logic          sar;
      logic          srv;
      logic          srl;
      logic [31:0]   sd;
      logic [1:0]    sr;
      logic [1:0]    mrr;
      logic [OW-1:0] exp;
   } vec_t;

   vec_t vecs[$];
   int   n_vec  = 0;
   int   n_fail = 0;

   task automatic add(input logic [1:0] arv, input logic sar, input logic srv, input logic srl,
                      input logic [31:0] sd, input logic [1:0] sr, input logic [1:0] mrr,
                      input logic esv, input logic [15:0] ea, input logic [7:0] el,
                      input logic [2:0] es, input logic [1:0] ear, input logic [1:0] erv,
                      input logic [1:0] erl, input logic [31:0] ed0, input logic [31:0] ed1,
                      input logic [1:0] er0, input logic [1:0] er1, input logic esr);
      vec_t v;
      v.arv = arv; v.sar = sar; v.srv = srv; v.srl = srl; v.sd = sd; v.sr = sr; v.mrr = mrr;
      v.exp = {esv, ea, el, es, ear, erv, erl, ed1, ed0, er1, er0, esr};
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input logic [OW-1:0] got, input logic [OW-1:0] want);
      n_vec++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", name, got, want);
      end
   endtask

   initial begin
      logic found;
      ARESET    = 1'b1;
      m_araddr  = {A1, A0};
      m_arlen   = {L1, L0};
      m_arsize  = {S1, S0};
      m_arvalid = 2'b00;
      m_rready  = 2'b00;
      s_arready = 1'b0;
      s_rdata   = Z;
      s_rresp   = OK;
      s_rvalid  = 1'b0;
      s_rlast   = 1'b0;

      //   arv   sar   srv   srl   sd            sr  mrr  | esv  ea  el  es  ear    erv    erl    ed0           ed1           er0 er1 esr
      // Tie straight after reset: M0 first.
      add(2'b11,1'b1,1'b0,1'b0,Z,            OK,2'b00, 1'b0,16'h0,8'd0,3'd0,2'b00,2'b00,2'b00,Z,            Z,            OK,OK,1'b0);
      add(2'b11,1'b1,1'b0,1'b0,Z,            OK,2'b00, 1'b1,A0,  L0,  S0,  2'b01,2'b00,2'b00,Z,            Z,            OK,OK,1'b0);
      add(2'b10,1'b1,1'b1,1'b1,32'h11111111, OK,2'b11, 1'b0,16'h0,8'd0,3'd0,2'b00,2'b01,2'b01,32'h11111111, Z,            OK,OK,1'b1);
      // M1 granted in the following IDLE cycle; slave stalls AR one cycle.
      add(2'b10,1'b1,1'b0,1'b0,Z,            OK,2'b00, 1'b0,16'h0,8'd0,3'd0,2'b00,2'b00,2'b00,Z,            Z,            OK,OK,1'b0);
      add(2'b10,1'b0,1'b0,1'b0,Z,            OK,2'b00, 1'b1,A1,  L1,  S1,  2'b00,2'b00,2'b00,Z,            Z,            OK,OK,1'b0);
      add(2'b10,1'b1,1'b0,1'b0,Z,            OK,2'b00, 1'b1,A1,  L1,  S1,  2'b10,2'b00,2'b00,Z,            Z,            OK,OK,1'b0);
      // M1 4-beat SLVERR burst; M0 requests after beat 1 and stays blocked; 3 cycles of backpressure.
      add(2'b00,1'b1,1'b1,1'b0,Z,            SE,2'b10, 1'b0,16'h0,8'd0,3'd0,2'b00,2'b10,2'b00,Z,            Z,            OK,SE,1'b1);
      add(2'b01,1'b1,1'b1,1'b0,Z,            SE,2'b10, 1'b0,16'h0,8'd0,3'd0,2'b00,2'b10,2'b00,Z,            Z,            OK,SE,1'b1);
      add(2'b01,1'b1,1'b1,1'b0,Z,            SE,2'b00, 1'b0,16'h0,8'd0,3'd0,2'b00,2'b10,2'b00,Z,            Z,            OK,SE,1'b0);
      add(2'b01,1'b1,1'b1,1'b0,Z,            SE,2'b00, 1'b0,16'h0,8'd0,3'd0,2'b00,2'b10,2'b00,Z,            Z,            OK,SE,1'b0);
      add(2'b01,1'b1,1'b1,1'b0,Z,            SE,2'b00, 1'b0,16'h0,8'd0,3'd0,2'b00,2'b10,2'b00,Z,            Z,            OK,SE,1'b0);
      add(2'b01,1'b1,1'b1,1'b0,Z,            SE,2'b10, 1'b0,16'h0,8'd0,3'd0,2'b00,2'b10,2'b00,Z,            Z,            OK,SE,1'b1);
      add(2'b01,1'b1,1'b1,1'b1,Z,            SE,2'b10, 1'b0,16'h0,8'd0,3'd0,2'b00,2'b10,2'b10,Z,            Z,            OK,SE,1'b1);
      // M0 AR appears two cycles after the RLAST handshake.
      add(2'b01,1'b1,1'b0,1'b0,Z,            OK,2'b00, 1'b0,16'h0,8'd0,3'd0,2'b00,2'b00,2'b00,Z,            Z,            OK,OK,1'b0);
      add(2'b01,1'b1,1'b0,1'b0,Z,            OK,2'b00, 1'b1,A0,  L0,  S0,  2'b01,2'b00,2'b00,Z,            Z,            OK,OK,1'b0);
      add(2'b10,1'b1,1'b1,1'b1,32'hCAFEF00D, OK,2'b01, 1'b0,16'h0,8'd0,3'd0,2'b00,2'b01,2'b01,32'hCAFEF00D, Z,            OK,OK,1'b1);
      // Tie after M0 served: M1 wins, then next tie goes back to M0.
      add(2'b11,1'b1,1'b0,1'b0,Z,            OK,2'b00, 1'b0,16'h0,8'd0,3'd0,2'b00,2'b00,2'b00,Z,            Z,            OK,OK,1'b0);
      add(2'b11,1'b1,1'b0,1'b0,Z,            OK,2'b00, 1'b1,A1,  L1,  S1,  2'b10,2'b00,2'b00,Z,            Z,            OK,OK,1'b0);
      add(2'b01,1'b1,1'b1,1'b1,Z,            SE,2'b10, 1'b0,16'h0,8'd0,3'd0,2'b00,2'b10,2'b10,Z,            Z,            OK,SE,1'b1);
      add(2'b11,1'b1,1'b0,1'b0,Z,            OK,2'b00, 1'b0,16'h0,8'd0,3'd0,2'b00,2'b00,2'b00,Z,            Z,            OK,OK,1'b0);
      add(2'b11,1'b1,1'b0,1'b0,Z,            OK,2'b00, 1'b1,A0,  L0,  S0,  2'b01,2'b00,2'b00,Z,            Z,            OK,OK,1'b0);
      add(2'b10,1'b1,1'b1,1'b1,32'h12345678, OK,2'b01, 1'b0,16'h0,8'd0,3'd0,2'b00,2'b01,2'b01,32'h12345678, Z,            OK,OK,1'b1);
      // M1 withdraws arvalid in ADDR: back to IDLE, history unchanged so M1 wins the next tie.
      add(2'b10,1'b1,1'b0,1'b0,Z,            OK,2'b00, 1'b0,16'h0,8'd0,3'd0,2'b00,2'b00,2'b00,Z,            Z,            OK,OK,1'b0);
      add(2'b00,1'b0,1'b0,1'b0,Z,            OK,2'b00, 1'b0,A1,  L1,  S1,  2'b00,2'b00,2'b00,Z,            Z,            OK,OK,1'b0);
      add(2'b11,1'b1,1'b0,1'b0,Z,            OK,2'b00, 1'b0,16'h0,8'd0,3'd0,2'b00,2'b00,2'b00,Z,            Z,            OK,OK,1'b0);
      add(2'b11,1'b1,1'b0,1'b0,Z,            OK,2'b00, 1'b1,A1,  L1,  S1,  2'b10,2'b00,2'b00,Z,            Z,            OK,OK,1'b0);
      // DATA with no beat: data routed to M1 only, M0 sees zeros.
      add(2'b01,1'b1,1'b0,1'b0,32'hAAAA5555, OK,2'b11, 1'b0,16'h0,8'd0,3'd0,2'b00,2'b00,2'b00,Z,            32'hAAAA5555, OK,OK,1'b1);
      add(2'b01,1'b1,1'b1,1'b1,Z,            SE,2'b10, 1'b0,16'h0,8'd0,3'd0,2'b00,2'b10,2'b10,Z,            Z,            OK,SE,1'b1);

      repeat (3) @(posedge ACLK);
      #1;
      ARESET = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         m_arvalid = vecs[i].arv;
         s_arready = vecs[i].sar;
         s_rvalid  = vecs[i].srv;
         s_rlast   = vecs[i].srl;
         s_rdata   = vecs[i].sd;
         s_rresp   = vecs[i].sr;
         m_rready  = vecs[i].mrr;
         @(negedge ACLK);
         chk($sformatf("vec%0d", i), obs, vecs[i].exp);
         @(posedge ACLK);
         #1;
      end

      // Reset asserted on beat 2 of an 8-beat M0 burst.
      m_arlen   = {L1, 8'd7};
      m_arvalid = 2'b01;
      s_arready = 1'b1;
      s_rvalid  = 1'b0;
      s_rlast   = 1'b0;
      s_rresp   = OK;
      m_rready  = 2'b01;
      @(posedge ACLK); #1;
      @(posedge ACLK); #1;
      m_arvalid = 2'b00;
      s_rvalid  = 1'b1;
      s_rdata   = 32'h0000_0001;
      @(posedge ACLK); #1;
      s_rdata   = 32'h0000_0002;
      #1;
      chk("beat2_routed", {{(OW-34){1'b0}}, m_rvalid, m_rdata[31:0]}, {{(OW-34){1'b0}}, 2'b01, 32'h0000_0002});
      ARESET = 1'b1;
      #1;
      chk("reset_async_zero", obs, {OW{1'b0}});
      m_arvalid = 2'b11;
      s_rvalid  = 1'b0;
      @(posedge ACLK); #1;
      ARESET = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge ACLK);
         if (s_arvalid) begin
            found = 1'b1;
            break;
         end
      end
      chk("post_reset_ar_seen", {{(OW-1){1'b0}}, found}, {{(OW-1){1'b0}}, 1'b1});
      chk("post_reset_tie_m0", {{(OW-18){1'b0}}, s_araddr, m_arready}, {{(OW-18){1'b0}}, A0, 2'b01});

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
